// File: rtl/exec_stage_pkg.sv
// Shared definitions for the execute stage: ALU command encodings, NZCV bit
// positions and the multiply sequencer state encoding.
package exec_stage_pkg;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_MOV = 4'd1,
    CMD_ADD = 4'd2,
    CMD_ADC = 4'd3,
    CMD_SUB = 4'd4,
    CMD_SBC = 4'd5,
    CMD_AND = 4'd6,
    CMD_ORR = 4'd7,
    CMD_EOR = 4'd8,
    CMD_MVN = 4'd9,
    CMD_MUL = 4'd10,
    CMD_CMP = 4'd11,
    CMD_TST = 4'd12,
    CMD_LDR = 4'd13,
    CMD_STR = 4'd14
  } alu_cmd_e;

  localparam int unsigned SR_N = 3;
  localparam int unsigned SR_Z = 2;
  localparam int unsigned SR_C = 1;
  localparam int unsigned SR_V = 0;

  typedef enum logic {
    MUL_IDLE    = 1'b0,
    MUL_HI_HELD = 1'b1
  } mul_state_e;

  // Commands whose C and V come from the adder; all others retain C and V.
  function automatic logic is_arith(input logic [3:0] cmd);
    case (alu_cmd_e'(cmd))
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC,
      CMD_CMP, CMD_LDR, CMD_STR: is_arith = 1'b1;
      default:                   is_arith = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exec_stage_alu.sv
// Combinational ALU: result and NZCV candidates for one command.
module alu
  import exec_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       cmd,
  input  logic             c_in,
  output logic [WIDTH-1:0] res,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v
);

  alu_cmd_e         op;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   sum;

  assign op = alu_cmd_e'(cmd);

  // Subtraction is a + ~b + cin, so one adder yields ARM-style C (no borrow) and V.
  always_comb begin
    sub  = (op == CMD_SUB) || (op == CMD_SBC) || (op == CMD_CMP);
    op_b = sub ? ~b : b;
    case (op)
      CMD_ADC, CMD_SBC: cin = c_in;
      CMD_SUB, CMD_CMP: cin = 1'b1;
      default:          cin = 1'b0;
    endcase
    sum = {1'b0, a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};

    res = '0;
    case (op)
      CMD_MOV:                   res = b;
      CMD_MVN:                   res = ~b;
      CMD_AND, CMD_TST:          res = a & b;
      CMD_ORR:                   res = a | b;
      CMD_EOR:                   res = a ^ b;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC,
      CMD_CMP, CMD_LDR, CMD_STR: res = sum[WIDTH-1:0];
      default:                   res = '0;
    endcase

    n = res[WIDTH-1];
    z = (res == '0);
    c = sum[WIDTH];
    v = (a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: ALU, NZCV register, two-cycle multiply sequencer, branch
// target adder and the EX/MEM pipeline register.
module exec_stage
  import exec_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic [3:0]       exec_cmd,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             wb_en,
  input  logic             status_w_en,
  input  logic             branch_taken,
  input  logic             dest_plus_one,
  input  logic [3:0]       dest,
  input  logic [WIDTH-1:0] val_rn,
  input  logic [WIDTH-1:0] val2,
  input  logic [WIDTH-1:0] val_rm,
  input  logic [WIDTH-1:0] pc,
  input  logic [23:0]      imm24,
  output logic [3:0]       sr,
  output logic             branch_taken_out,
  output logic [WIDTH-1:0] branch_addr,
  output logic             mul_pending,
  output logic [WIDTH-1:0] em_alu_res,
  output logic [WIDTH-1:0] em_st_val,
  output logic [3:0]       em_dest,
  output logic             em_wb_en,
  output logic             em_mem_r_en,
  output logic             em_mem_w_en
);

  mul_state_e         state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               is_mul, mul1, mul2;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   alu_res, ex_res;
  logic               alu_n, alu_z, alu_c, alu_v;
  logic               wb_ex;
  logic [3:0]         dest_ex;
  logic [3:0]         sr_d;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a    (val_rn),
    .b    (val2),
    .cmd  (exec_cmd),
    .c_in (sr[SR_C]),
    .res  (alu_res),
    .n    (alu_n),
    .z    (alu_z),
    .c    (alu_c),
    .v    (alu_v)
  );

  assign is_mul  = (exec_cmd == CMD_MUL);
  assign mul1    = is_mul && !dest_plus_one;
  assign mul2    = is_mul && dest_plus_one;
  assign product = {{WIDTH{1'b0}}, val_rn} * {{WIDTH{1'b0}}, val2};

  assign branch_addr      = pc + {{(WIDTH-26){imm24[23]}}, imm24, 2'b00};
  assign branch_taken_out = branch_taken && !freeze;
  assign mul_pending      = (state_q == MUL_HI_HELD);

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    if (!freeze) begin
      if (mul1) begin
        state_d = MUL_HI_HELD;
        hi_d    = product[2*WIDTH-1:WIDTH];
      end else if (mul2) begin
        state_d = MUL_IDLE;
      end
    end
  end

  // A MUL2 with no held high word is squashed rather than writing garbage.
  always_comb begin
    ex_res  = alu_res;
    wb_ex   = wb_en;
    dest_ex = dest;
    if (mul1) begin
      ex_res = product[WIDTH-1:0];
    end else if (mul2) begin
      dest_ex = dest + 4'd1;
      if (state_q == MUL_HI_HELD) begin
        ex_res = hi_q;
      end else begin
        ex_res = '0;
        wb_ex  = 1'b0;
      end
    end
  end

  always_comb begin
    sr_d = sr;
    if (status_w_en && !mul2) begin
      sr_d[SR_N] = mul1 ? ex_res[WIDTH-1] : alu_n;
      sr_d[SR_Z] = mul1 ? (ex_res == '0) : alu_z;
      if (is_arith(exec_cmd)) begin
        sr_d[SR_C] = alu_c;
        sr_d[SR_V] = alu_v;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MUL_IDLE;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr          <= '0;
      em_alu_res  <= '0;
      em_st_val   <= '0;
      em_dest     <= '0;
      em_wb_en    <= 1'b0;
      em_mem_r_en <= 1'b0;
      em_mem_w_en <= 1'b0;
    end else if (!freeze) begin
      sr          <= sr_d;
      em_alu_res  <= ex_res;
      em_st_val   <= val_rm;
      em_dest     <= dest_ex;
      em_wb_en    <= wb_ex;
      em_mem_r_en <= mem_r_en;
      em_mem_w_en <= mem_w_en;
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: arithmetic reference model compared
// every cycle, plus hand-computed literal expectations at key points.
module tb_exec_stage;
  import exec_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze;
  logic [3:0]  exec_cmd;
  logic        mem_r_en, mem_w_en, wb_en, status_w_en, branch_taken, dest_plus_one;
  logic [3:0]  dest;
  logic [31:0] val_rn, val2, val_rm, pc;
  logic [23:0] imm24;
  logic [3:0]  sr;
  logic        branch_taken_out;
  logic [31:0] branch_addr;
  logic        mul_pending;
  logic [31:0] em_alu_res, em_st_val;
  logic [3:0]  em_dest;
  logic        em_wb_en, em_mem_r_en, em_mem_w_en;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // reference model state
  logic [31:0] m_res, m_st, m_hi;
  logic [3:0]  m_dest, m_sr;
  logic        m_wb, m_mr, m_mw, m_pend;

  exec_stage #(.WIDTH(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .freeze           (freeze),
    .exec_cmd         (exec_cmd),
    .mem_r_en         (mem_r_en),
    .mem_w_en         (mem_w_en),
    .wb_en            (wb_en),
    .status_w_en      (status_w_en),
    .branch_taken     (branch_taken),
    .dest_plus_one    (dest_plus_one),
    .dest             (dest),
    .val_rn           (val_rn),
    .val2             (val2),
    .val_rm           (val_rm),
    .pc               (pc),
    .imm24            (imm24),
    .sr               (sr),
    .branch_taken_out (branch_taken_out),
    .branch_addr      (branch_addr),
    .mul_pending      (mul_pending),
    .em_alu_res       (em_alu_res),
    .em_st_val        (em_st_val),
    .em_dest          (em_dest),
    .em_wb_en         (em_wb_en),
    .em_mem_r_en      (em_mem_r_en),
    .em_mem_w_en      (em_mem_w_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_res = '0; m_st = '0; m_hi = '0; m_dest = '0; m_sr = '0;
    m_wb = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_pend = 1'b0;
  endtask

  // Architectural effect of one rising edge, from the instruction semantics.
  task automatic model_edge();
    logic [63:0] full, prod;
    longint      sres;
    logic [31:0] r;
    logic        cf, vf, arith, w, borrow, cin;
    logic [3:0]  d;
    if (!rst_n) begin model_reset(); return; end
    if (freeze) return;
    r = '0; cf = m_sr[1]; vf = m_sr[0]; arith = 1'b0; w = wb_en; d = dest;
    case (exec_cmd)
      CMD_MOV: r = val2;
      CMD_MVN: r = ~val2;
      CMD_AND, CMD_TST: r = val_rn & val2;
      CMD_ORR: r = val_rn | val2;
      CMD_EOR: r = val_rn ^ val2;
      CMD_ADD, CMD_ADC, CMD_LDR, CMD_STR: begin
        cin  = (exec_cmd == CMD_ADC) ? m_sr[1] : 1'b0;
        full = 64'(val_rn) + 64'(val2) + 64'(cin);
        sres = longint'(signed'(val_rn)) + longint'(signed'(val2)) + longint'(cin);
        r = full[31:0];
        cf = (full > 64'h0000_0000_FFFF_FFFF);
        vf = (sres != longint'(signed'(r)));
        arith = 1'b1;
      end
      CMD_SUB, CMD_CMP, CMD_SBC: begin
        borrow = (exec_cmd == CMD_SBC) ? !m_sr[1] : 1'b0;
        full = 64'(val_rn) - 64'(val2) - 64'(borrow);
        sres = longint'(signed'(val_rn)) - longint'(signed'(val2)) - longint'(borrow);
        r = full[31:0];
        cf = (64'(val_rn) >= 64'(val2) + 64'(borrow));
        vf = (sres != longint'(signed'(r)));
        arith = 1'b1;
      end
      CMD_MUL: begin
        if (!dest_plus_one) begin
          prod = 64'(val_rn) * 64'(val2);
          r = prod[31:0];
          m_hi = prod[63:32];
          m_pend = 1'b1;
        end else begin
          d = 4'((int'(dest) + 1) % 16);
          if (m_pend) r = m_hi;
          else begin r = '0; w = 1'b0; end
          m_pend = 1'b0;
        end
      end
      default: r = '0;
    endcase
    if (status_w_en && !(exec_cmd == CMD_MUL && dest_plus_one)) begin
      m_sr[3] = r[31];
      m_sr[2] = (r == 32'd0);
      if (arith) begin m_sr[1] = cf; m_sr[0] = vf; end
    end
    m_res = r; m_st = val_rm; m_dest = d; m_wb = w; m_mr = mem_r_en; m_mw = mem_w_en;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("em_alu_res", em_alu_res, m_res);
      check("em_st_val", em_st_val, m_st);
      check("em_dest", 32'(em_dest), 32'(m_dest));
      check("em_wb_en", 32'(em_wb_en), 32'(m_wb));
      check("em_mem_r_en", 32'(em_mem_r_en), 32'(m_mr));
      check("em_mem_w_en", 32'(em_mem_w_en), 32'(m_mw));
      check("sr", 32'(sr), 32'(m_sr));
      check("mul_pending", 32'(mul_pending), 32'(m_pend));
      check("branch_addr", branch_addr, pc + 32'(int'(signed'(imm24)) * 4));
      check("branch_taken_out", 32'(branch_taken_out), 32'(branch_taken && !freeze));
    end
  end

  task automatic setup(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] d, input logic s, input logic w, input logic dpo);
    exec_cmd = c; val_rn = a; val2 = b; dest = d; status_w_en = s; wb_en = w;
    dest_plus_one = dpo; mem_r_en = 1'b0; mem_w_en = 1'b0; freeze = 1'b0;
    branch_taken = 1'b0; val_rm = a ^ 32'hA5A5_0F0F; pc = b; imm24 = a[23:0];
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                    input logic [3:0] d, input logic s, input logic w, input logic dpo);
    setup(c, a, b, d, s, w, dpo);
    tick();
  endtask

  initial begin
    rst_n = 1'b1;
    setup(CMD_ADD, 32'd7, 32'd8, 4'd1, 1'b0, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    model_reset();
    chk_en = 1'b1;
    #1;
    check("rst_res_async", em_alu_res, 32'h0);
    check("rst_sr_async", 32'(sr), 32'h0);
    tick(); tick();
    check("rst_res_held", em_alu_res, 32'h0);
    check("rst_wb_held", 32'(em_wb_en), 32'h0);
    rst_n = 1'b1;
    tick();
    check("first_add", em_alu_res, 32'd15);

    op(CMD_ADD, 32'h7FFF_FFFF, 32'h1, 4'd2, 1'b1, 1'b1, 1'b0);
    check("add_ovf_res", em_alu_res, 32'h8000_0000);
    check("add_ovf_sr", 32'(sr), 32'b1001);
    op(CMD_TST, 32'hF0, 32'h0F, 4'd2, 1'b1, 1'b0, 1'b0);
    check("tst_keeps_cv", 32'(sr), 32'b0101);
    op(CMD_SUB, 32'd5, 32'd5, 4'd2, 1'b1, 1'b1, 1'b0);
    check("sub_zero_sr", 32'(sr), 32'b0110);
    op(CMD_ADC, 32'd1, 32'd2, 4'd2, 1'b0, 1'b1, 1'b0);
    check("adc_res", em_alu_res, 32'd4);
    op(CMD_CMP, 32'd3, 32'd5, 4'd2, 1'b1, 1'b0, 1'b0);
    check("cmp_wb", 32'(em_wb_en), 32'h0);
    check("cmp_sr", 32'(sr), 32'b1000);
    op(CMD_SBC, 32'd10, 32'd3, 4'd5, 1'b0, 1'b1, 1'b0);
    check("sbc_borrow", em_alu_res, 32'd6);
    op(CMD_ADD, 32'hFFFF_FFFF, 32'h1, 4'd5, 1'b1, 1'b1, 1'b0);
    check("add_carry_sr", 32'(sr), 32'b0110);
    op(CMD_SUB, 32'h8000_0000, 32'h1, 4'd5, 1'b1, 1'b1, 1'b0);
    check("sub_ovf_sr", 32'(sr), 32'b0011);
    op(CMD_ORR, 32'hF0, 32'h0F, 4'd6, 1'b0, 1'b1, 1'b0);
    check("orr_res", em_alu_res, 32'hFF);
    op(CMD_EOR, 32'hFF, 32'h0F, 4'd6, 1'b0, 1'b1, 1'b0);
    check("eor_res", em_alu_res, 32'hF0);
    op(CMD_MVN, 32'h0, 32'h0, 4'd6, 1'b1, 1'b1, 1'b0);
    check("mvn_res", em_alu_res, 32'hFFFF_FFFF);
    check("mvn_sr", 32'(sr), 32'b1011);
    op(CMD_MOV, 32'h0, 32'h0, 4'd6, 1'b1, 1'b1, 1'b0);
    check("mov_zero_sr", 32'(sr), 32'b0111);

    // two-cycle multiply
    op(CMD_MUL, 32'hFFFF_FFFF, 32'h2, 4'd3, 1'b1, 1'b1, 1'b0);
    check("mul1_lo", em_alu_res, 32'hFFFF_FFFE);
    check("mul1_dest", 32'(em_dest), 32'd3);
    check("mul1_pending", 32'(mul_pending), 32'h1);
    check("mul1_sr", 32'(sr), 32'b1011);
    op(CMD_MUL, 32'h0, 32'h0, 4'd3, 1'b1, 1'b1, 1'b1);
    check("mul2_hi", em_alu_res, 32'h1);
    check("mul2_dest", 32'(em_dest), 32'd4);
    check("mul2_pending", 32'(mul_pending), 32'h0);
    check("mul2_sr_kept", 32'(sr), 32'b1011);
    op(CMD_MUL, 32'h1234, 32'h5, 4'd7, 1'b0, 1'b1, 1'b1);
    check("mul2_idle_res", em_alu_res, 32'h0);
    check("mul2_idle_wb", 32'(em_wb_en), 32'h0);
    op(CMD_MUL, 32'h0001_0000, 32'h0003_0000, 4'd1, 1'b0, 1'b1, 1'b0);
    op(CMD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 1'b0, 1'b1, 1'b0);
    check("mul_restart_lo", em_alu_res, 32'h1);
    op(CMD_MUL, 32'h0, 32'h0, 4'd1, 1'b0, 1'b1, 1'b1);
    check("mul_restart_hi", em_alu_res, 32'hFFFF_FFFE);

    // freeze while the high word is held
    op(CMD_MUL, 32'h1234_5678, 32'h100, 4'd15, 1'b1, 1'b1, 1'b0);
    check("mulf_sr", 32'(sr), 32'b0011);
    setup(CMD_ADD, 32'h7FFF_FFFF, 32'h1, 4'd9, 1'b1, 1'b1, 1'b0);
    freeze = 1'b1; branch_taken = 1'b1;
    #1;
    check("freeze_bt_gated", 32'(branch_taken_out), 32'h0);
    tick(); tick(); tick();
    check("freeze_res", em_alu_res, 32'h3456_7800);
    check("freeze_sr", 32'(sr), 32'b0011);
    check("freeze_pending", 32'(mul_pending), 32'h1);
    op(CMD_MUL, 32'h0, 32'h0, 4'd15, 1'b0, 1'b1, 1'b1);
    check("mulf_hi", em_alu_res, 32'h12);
    check("mulf_dest_wrap", 32'(em_dest), 32'd0);

    // asynchronous reset while the high word is held
    op(CMD_MUL, 32'h3, 32'h4, 4'd2, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_pending", 32'(mul_pending), 32'h0);
    check("rst_mid_res", em_alu_res, 32'h0);
    tick();
    rst_n = 1'b1;
    op(CMD_MUL, 32'h0, 32'h0, 4'd2, 1'b0, 1'b1, 1'b1);
    check("rst_mid_mul2", 32'(em_wb_en), 32'h0);

    // branch target and memory address
    setup(CMD_MOV, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    pc = 32'h100; imm24 = 24'hFF_FFFE; branch_taken = 1'b1;
    #1;
    check("branch_back", branch_addr, 32'h0000_00F8);
    check("branch_taken_out", 32'(branch_taken_out), 32'h1);
    pc = 32'h1000; imm24 = 24'h00_0010;
    #1;
    check("branch_fwd", branch_addr, 32'h0000_1040);
    tick();
    setup(CMD_LDR, 32'h400, 32'h8, 4'd8, 1'b0, 1'b1, 1'b0);
    mem_r_en = 1'b1;
    tick();
    check("ldr_addr", em_alu_res, 32'h408);
    check("ldr_ren", 32'(em_mem_r_en), 32'h1);
    setup(CMD_STR, 32'h400, 32'h10, 4'd8, 1'b0, 1'b0, 1'b0);
    mem_w_en = 1'b1; val_rm = 32'hDEAD_BEEF;
    tick();
    check("str_addr", em_alu_res, 32'h410);
    check("str_data", em_st_val, 32'hDEAD_BEEF);
    check("str_wen", 32'(em_mem_w_en), 32'h1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
# exec_stage

Execute stage of the five-stage ARM pipeline: consumes the decoded control bundle (`exec_cmd`, memory/write-back enables, `status_w_en`, `imm`, `branch_taken`, `dest_plus_one`) and the register operands latched in ID/EX. It evaluates the ALU, owns the NZCV status register, sequences the two-cycle multiply, and computes branch and memory addresses. It drives the registered EX/MEM pipeline register toward the memory stage.

## Interface
- `WIDTH`, 32, datapath width. Fixed at 32.

- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `freeze`  in  1  hazard stall; holds all internal state and outputs.
- `exec_cmd`  in  4  ALU command, encoded by the shared ALU command include.
- `mem_r_en`, `mem_w_en`, `wb_en`  in  1 each  decoded enables.
- `status_w_en`  in  1  update NZCV from this instruction.
- `branch_taken`  in  1  branch decoded this cycle.
- `dest_plus_one`  in  1  second multiply cycle; write `dest+1`.
- `dest`  in  4  destination register index.
- `val_rn`, `val2`, `val_rm`  in  32 each  operand 1, operand 2 (post-shift/immediate), store data.
- `pc`  in  32  PC of this instruction plus 4.
- `imm24`  in  24  branch offset.
- `sr`  out  4  NZCV, ordered {N,Z,C,V}, fed back to condition check.
- `branch_taken_out`  out  1  combinational copy of `branch_taken`, gated by `!freeze`.
- `branch_addr`  out  32  `pc + (sign_extend(imm24) << 2)`, combinational.
- `mul_pending`  out  1  MUL1 issued, MUL2 not yet consumed.
- `em_alu_res`, `em_st_val`  out  32 each  registered result/address and store data.
- `em_dest`  out  4  registered destination (already incremented for MUL2).
- `em_wb_en`, `em_mem_r_en`, `em_mem_w_en`  out  1 each  registered enables.

## Operation
- ALU, with a = `val_rn` and b = `val2`:
  - MOV: b. MVN: ~b.
  - ADD: a+b. ADC: a+b+C. SUB: a-b. SBC: a-b-!C.
  - AND, ORR, EOR: bitwise.
  - CMP: as SUB. TST: as AND.
  - LDR/STR: a+b (address).
- Flags:
  - N is result bit 31. Z is result==0.
  - Add-type ops: C is carry-out, V is signed overflow.
  - Sub-type ops: C=1 means no borrow, V is signed overflow.
  - Logic ops, MOV, MVN and MUL: C and V are retained.
- ADC/SBC use the registered C, not a same-cycle update.
- Multiply FSM, states IDLE and HI_HELD:
  - MUL1 in IDLE: computes the unsigned 64-bit product a*b, outputs the low word, latches the high word, and moves to HI_HELD. `mul_pending` is 1 in HI_HELD.
  - MUL2 (with `dest_plus_one`) in HI_HELD: outputs the latched high word with `em_dest = dest+1` (mod 16), then returns to IDLE.
  - MUL2 in IDLE: outputs 0, `em_wb_en` forced 0.
  - MUL1 in HI_HELD: restarts, overwriting the latched word.
  - Flags on MUL1 reflect the low word; MUL2 never writes flags.
- `em_st_val = val_rm`; `em_dest = dest` except on MUL2.
- Freeze: the EX/MEM register, SR, FSM state and high-word latch all hold. Combinational outputs still compute, but `branch_taken_out` is 0.

## Timing
- Result latency is 1 cycle: inputs at edge k appear on `em_*` after edge k+1.
- SR updates on the same edge as `em_*`, and is visible to the next instruction.
- `branch_addr`/`branch_taken_out` have zero latency, for same-cycle IF redirect.
- Reset (asynchronous, any cycle, including mid-multiply):
  - All `em_*` = 0, `sr` = 0, FSM = IDLE, `mul_pending` = 0, high latch = 0.
  - Takes effect immediately, not at the next edge.
- `status_w_en` with `freeze`=1 writes nothing.

## Structure
- ALU command encodings live in the shared ALU command include; do not redefine them locally.
- Shared package also holds the NZCV bit positions and the FSM state encoding.
- One sub-module, `alu`: purely combinational `{a, b, cmd, c_in} -> {res, n, z, c, v}`.
- `exec_stage` contains the SR, the multiply FSM and latch, the branch adder and the EX/MEM register.

## Test plan
- Reset: hold `rst_n`=0 while driving ADD -> all `em_*` 0, `sr`=0; release -> next edge shows the ADD result.
- ADD overflow: 0x7FFFFFFF + 0x00000001, `status_w_en`=1 -> `em_alu_res`=0x80000000, `sr`={1,0,0,1}.
- Carry chain: SUB 5-5 with S -> result 0, sr Z=1, C=1; then ADC 1+2 -> 0x00000004. CMP 3-5 -> no write-back, N=1, C=0.
- Multiply: MUL1 0xFFFFFFFF*2 with `dest`=3 -> res 0xFFFFFFFE to r3, `mul_pending`=1; MUL2 -> res 0x00000001 to r4, `mul_pending`=0.
- Freeze during multiply: MUL1, then `freeze`=1 for 3 cycles -> `em_*` and `sr` constant; MUL2 after release -> correct high word. Reset asserted in HI_HELD -> `mul_pending`=0 immediately.
- Branch/memory: `pc`=0x100, `imm24`=0xFFFFFE -> `branch_addr`=0x000000F8 same cycle. LDR with a=0x400, b=0x8 -> `em_alu_res`=0x408, `em_mem_r_en`=1.
